sha3_byte_packer: RTL and testbench

Byte-stream front end for the SHA-3 core wrapper. It accepts a message one byte at a time with a valid/ready handshake and packs the bytes into 64-bit words. It drives the core's word strobe, last flag and byte count, and honours the core's buffer-full backpressure. After a message it holds off the next message until the core signals a completed digest.

---
 rtl/sha3_pkg.sv | 37 +++
 rtl/sha3_byte_packer.sv | 172 +++++++++++++++++
 tb/tb_sha3_byte_packer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// ---------------------------------------------------------------------------
// sha3_pkg
//
// Purpose:
//   Shared constants and types for the SHA-3 byte-stream front end.
//   Holds the word geometry, the lane-counter width, the packer state
//   enumeration and a small helper that maps a lane index to the MSB of
//   its byte inside the packed word.
//
// Contents:
//   WORD_W          - width of a packed word handed to the core (64)
//   BYTES_PER_WORD  - bytes per packed word (8)
//   LANE_W          - width of the byte-lane counter
//   state_t         - packer states {IDLE, FILL, EMIT, PAD, WAIT_DIG}
//   lane_msb()      - bit index of the top bit of byte lane k
// ---------------------------------------------------------------------------
package sha3_pkg;

    localparam int WORD_W         = 64;
    localparam int BYTES_PER_WORD = 8;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        EMIT     = 3'd2,
        PAD      = 3'd3,
        WAIT_DIG = 3'd4
    } state_t;

    // The k-th byte of a word occupies bits [63-8k -: 8], so the first byte
    // received ends up in the most significant byte of the word.
    function automatic logic [5:0] lane_msb(input logic [LANE_W-1:0] lane);
        return 6'd63 - {lane, 3'b000};
    endfunction

endpackage

// File: rtl/sha3_byte_packer.sv
// ---------------------------------------------------------------------------
// sha3_byte_packer
//
// Purpose:
//   Byte-stream front end for the SHA-3 core wrapper. Accepts a message one
//   byte at a time over a valid/ready handshake, packs the bytes MSB-first
//   into 64-bit words and strobes each word into the core, honouring the
//   core's buffer-full backpressure. After the last word of a message it
//   optionally waits for a rising digest-ready before taking a new message.
//
// Parameters:
//   HOLD_FOR_DIGEST - 1: wait for a 0->1 on IDIGEST_READY after a message
//                     0: go straight back to accepting bytes
//
// Ports:
//   ICLK          in   clock, rising edge
//   IRST          in   asynchronous active-high reset
//   IBYTE         in   message byte
//   IBYTE_VALID   in   IBYTE is valid
//   IBYTE_LAST    in   IBYTE is the final byte of the message
//   OBYTE_READY   out  packer accepts a byte this cycle (registered)
//   OWORD         out  packed word to the core
//   OWORD_VALID   out  single-cycle word strobe
//   OWORD_LAST    out  final word of the message
//   OWORD_BYTES   out  valid byte count of a partial last word, else 0
//   IFULL         in   core buffer full; no strobe while high
//   IDIGEST_READY in   core digest ready
//   OBUSY         out  state is not IDLE
// ---------------------------------------------------------------------------
module sha3_byte_packer
    import sha3_pkg::*;
#(
    parameter bit HOLD_FOR_DIGEST = 1'b1
) (
    input  logic              ICLK,
    input  logic              IRST,
    input  logic [7:0]        IBYTE,
    input  logic              IBYTE_VALID,
    input  logic              IBYTE_LAST,
    output logic              OBYTE_READY,
    output logic [WORD_W-1:0] OWORD,
    output logic              OWORD_VALID,
    output logic              OWORD_LAST,
    output logic [2:0]        OWORD_BYTES,
    input  logic              IFULL,
    input  logic              IDIGEST_READY,
    output logic              OBUSY
);

    state_t              state;
    logic [LANE_W-1:0]   lane_cnt;
    logic [WORD_W-1:0]   word_reg;
    logic                msg_last;
    logic [LANE_W-1:0]   last_bytes;
    logic                dig_prev;
    logic                byte_xfer;

    // A byte moves only when the source offers it and the registered ready
    // is high, so ready stays low for the first cycle after reset.
    assign byte_xfer = IBYTE_VALID & OBYTE_READY;

    // Packer state machine with registered outputs.
    //
    // OBYTE_READY and OBUSY are written alongside every state change so that
    // they always reflect the state being entered; this keeps them
    // registered without a separate next-state decoder.
    //
    // last_bytes holds the lane count of the final byte; it wraps to 0 when
    // the last byte fills all eight lanes, which is exactly the case that
    // needs an extra all-zero padding word flagged as last.
    //
    // The previous digest-ready sample is refreshed in every state so that a
    // level already high when WAIT_DIG is entered is not mistaken for a rise.
    always_ff @(posedge ICLK or posedge IRST) begin
        if (IRST) begin
            state       <= IDLE;
            lane_cnt    <= '0;
            word_reg    <= '0;
            msg_last    <= 1'b0;
            last_bytes  <= '0;
            dig_prev    <= 1'b0;
            OBYTE_READY <= 1'b0;
            OWORD       <= '0;
            OWORD_VALID <= 1'b0;
            OWORD_LAST  <= 1'b0;
            OWORD_BYTES <= 3'd0;
            OBUSY       <= 1'b0;
        end else begin
            dig_prev    <= IDIGEST_READY;
            OWORD_VALID <= 1'b0;
            OWORD_LAST  <= 1'b0;
            OWORD_BYTES <= 3'd0;

            case (state)
                IDLE, FILL: begin
                    OBYTE_READY <= 1'b1;
                    if (byte_xfer) begin
                        word_reg[lane_msb(lane_cnt) -: 8] <= IBYTE;
                        lane_cnt <= lane_cnt + 1'b1;
                        OBUSY    <= 1'b1;
                        if (IBYTE_LAST || (lane_cnt == LANE_W'(BYTES_PER_WORD - 1))) begin
                            state       <= EMIT;
                            OBYTE_READY <= 1'b0;
                            msg_last    <= IBYTE_LAST;
                            last_bytes  <= lane_cnt + 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end

                EMIT: begin
                    if (!IFULL) begin
                        OWORD_VALID <= 1'b1;
                        OWORD       <= word_reg;
                        word_reg    <= '0;
                        lane_cnt    <= '0;
                        if (msg_last && (last_bytes != '0)) begin
                            OWORD_LAST  <= 1'b1;
                            OWORD_BYTES <= 3'(last_bytes);
                            msg_last    <= 1'b0;
                            if (HOLD_FOR_DIGEST) begin
                                state <= WAIT_DIG;
                            end else begin
                                state       <= IDLE;
                                OBYTE_READY <= 1'b1;
                                OBUSY       <= 1'b0;
                            end
                        end else if (msg_last) begin
                            state <= PAD;
                        end else begin
                            state       <= IDLE;
                            OBYTE_READY <= 1'b1;
                            OBUSY       <= 1'b0;
                        end
                    end
                end

                PAD: begin
                    if (!IFULL) begin
                        OWORD_VALID <= 1'b1;
                        OWORD       <= '0;
                        OWORD_LAST  <= 1'b1;
                        msg_last    <= 1'b0;
                        if (HOLD_FOR_DIGEST) begin
                            state <= WAIT_DIG;
                        end else begin
                            state       <= IDLE;
                            OBYTE_READY <= 1'b1;
                            OBUSY       <= 1'b0;
                        end
                    end
                end

                WAIT_DIG: begin
                    if (IDIGEST_READY && !dig_prev) begin
                        state       <= IDLE;
                        OBYTE_READY <= 1'b1;
                        OBUSY       <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    OBYTE_READY <= 1'b1;
                    OBUSY       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_byte_packer.sv
// ---------------------------------------------------------------------------
// tb_sha3_byte_packer
//
// Purpose:
//   Self-checking bench for sha3_byte_packer (HOLD_FOR_DIGEST=1). Directed
//   scenarios plus randomized messages are compared against a reference
//   model that slices each message into 8-byte words and appends the last
//   word / padding word directly from the message length.
// ---------------------------------------------------------------------------
module tb_sha3_byte_packer;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [63:0] word;
        logic        last;
        logic [2:0]  nbytes;
    } strobe_t;

    logic        ICLK;
    logic        IRST;
    logic [7:0]  IBYTE;
    logic        IBYTE_VALID;
    logic        IBYTE_LAST;
    logic        OBYTE_READY;
    logic [63:0] OWORD;
    logic        OWORD_VALID;
    logic        OWORD_LAST;
    logic [2:0]  OWORD_BYTES;
    logic        IFULL;
    logic        IDIGEST_READY;
    logic        OBUSY;

    int      compared   = 0;
    int      mismatched = 0;
    bit      rand_full  = 0;
    logic    ifull_at_edge = 1'b0;
    strobe_t obs_q[$];
    strobe_t exp_q[$];

    sha3_byte_packer #(.HOLD_FOR_DIGEST(1'b1)) dut (
        .ICLK          (ICLK),
        .IRST          (IRST),
        .IBYTE         (IBYTE),
        .IBYTE_VALID   (IBYTE_VALID),
        .IBYTE_LAST    (IBYTE_LAST),
        .OBYTE_READY   (OBYTE_READY),
        .OWORD         (OWORD),
        .OWORD_VALID   (OWORD_VALID),
        .OWORD_LAST    (OWORD_LAST),
        .OWORD_BYTES   (OWORD_BYTES),
        .IFULL         (IFULL),
        .IDIGEST_READY (IDIGEST_READY),
        .OBUSY         (OBUSY)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        ICLK = 1'b0;
        forever #5 ICLK = ~ICLK;
    end

    // Hard stop in case anything stalls beyond every local bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Remember the IFULL value the DUT saw at each rising edge.
    always @(posedge ICLK) ifull_at_edge <= IFULL;

    // Collect every strobe and make sure it never coincided with IFULL=1.
    always @(negedge ICLK) begin
        if (OWORD_VALID) begin
            obs_q.push_back('{OWORD, OWORD_LAST, OWORD_BYTES});
            checkOutput("strobe_with_full", {63'd0, ifull_at_edge}, 64'd0);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model: cut the message into 8-byte words, first byte in the
    // top byte; a partial tail is the last word, an exact multiple of 8 is
    // followed by an all-zero last word.
    function automatic void buildExpected(input byte_q_t msg);
        int len = msg.size();
        int nw  = (len + 7) / 8;
        exp_q.delete();
        for (int w = 0; w < nw; w++) begin
            logic [63:0] word = 64'd0;
            for (int j = 0; j < 8; j++) begin
                int idx = w * 8 + j;
                if (idx < len) word |= {56'd0, msg[idx]} << (56 - 8 * j);
            end
            if (w != nw - 1) begin
                exp_q.push_back('{word, 1'b0, 3'd0});
            end else if (len % 8 == 0) begin
                exp_q.push_back('{word, 1'b0, 3'd0});
                exp_q.push_back('{64'd0, 1'b1, 3'd0});
            end else begin
                exp_q.push_back('{word, 1'b1, 3'(len % 8)});
            end
        end
    endfunction

    task automatic sendByte(input logic [7:0] b, input logic last);
        int n = 0;
        IBYTE       = b;
        IBYTE_LAST  = last;
        IBYTE_VALID = 1'b1;
        if (rand_full) IFULL = ($urandom_range(0, 2) == 0);
        while (!OBYTE_READY && n < 500) begin
            @(negedge ICLK);
            n++;
            if (rand_full) IFULL = ($urandom_range(0, 2) == 0);
        end
        checkOutput("byte_accept", {63'd0, OBYTE_READY}, 64'd1);
        @(negedge ICLK);
        IBYTE_VALID = 1'b0;
        IBYTE_LAST  = 1'b0;
    endtask

    task automatic applyStimulus(input byte_q_t msg);
        for (int i = 0; i < msg.size(); i++)
            sendByte(msg[i], (i == msg.size() - 1));
    endtask

    task automatic waitStrobes();
        int n = 0;
        while (obs_q.size() < exp_q.size() && n < 1000) begin
            @(negedge ICLK);
            n++;
            if (rand_full) IFULL = ($urandom_range(0, 2) == 0);
        end
        IFULL = 1'b0;
        repeat (2) @(negedge ICLK);
    endtask

    task automatic compareStrobes(input string tag);
        checkOutput($sformatf("%s_count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                checkOutput($sformatf("%s_word%0d", tag, i), obs_q[i].word, exp_q[i].word);
                checkOutput($sformatf("%s_last%0d", tag, i), {63'd0, obs_q[i].last},
                            {63'd0, exp_q[i].last});
                checkOutput($sformatf("%s_bytes%0d", tag, i), {61'd0, obs_q[i].nbytes},
                            {61'd0, exp_q[i].nbytes});
            end
        end
        obs_q.delete();
    endtask

    task automatic releaseDigest(input string tag);
        IDIGEST_READY = 1'b0;
        @(negedge ICLK);
        IDIGEST_READY = 1'b1;
        @(negedge ICLK);
        IDIGEST_READY = 1'b0;
        @(negedge ICLK);
        checkOutput($sformatf("%s_idle_busy", tag), {63'd0, OBUSY}, 64'd0);
        checkOutput($sformatf("%s_idle_ready", tag), {63'd0, OBYTE_READY}, 64'd1);
    endtask

    task automatic runMessage(input byte_q_t msg, input string tag);
        buildExpected(msg);
        applyStimulus(msg);
        waitStrobes();
        compareStrobes(tag);
        checkOutput($sformatf("%s_wait_busy", tag), {63'd0, OBUSY}, 64'd1);
        checkOutput($sformatf("%s_wait_ready", tag), {63'd0, OBYTE_READY}, 64'd0);
        releaseDigest(tag);
    endtask

    initial begin
        byte_q_t msg;

        IRST          = 1'b1;
        IBYTE         = 8'h00;
        IBYTE_VALID   = 1'b0;
        IBYTE_LAST    = 1'b0;
        IFULL         = 1'b0;
        IDIGEST_READY = 1'b0;

        // Reset values.
        repeat (2) @(negedge ICLK);
        checkOutput("rst_oword", OWORD, 64'd0);
        checkOutput("rst_valid", {63'd0, OWORD_VALID}, 64'd0);
        checkOutput("rst_last", {63'd0, OWORD_LAST}, 64'd0);
        checkOutput("rst_bytes", {61'd0, OWORD_BYTES}, 64'd0);
        checkOutput("rst_busy", {63'd0, OBUSY}, 64'd0);
        checkOutput("rst_ready", {63'd0, OBYTE_READY}, 64'd0);
        IRST = 1'b0;
        @(negedge ICLK);
        checkOutput("ready_after_rst", {63'd0, OBYTE_READY}, 64'd1);

        // Short message "abc".
        msg = '{8'h61, 8'h62, 8'h63};
        runMessage(msg, "abc");

        // Exactly eight bytes: full word then padding word.
        msg.delete();
        for (int i = 0; i < 8; i++) msg.push_back(8'(i));
        runMessage(msg, "eight");

        // Seventeen bytes: two full words and a one-byte tail.
        msg.delete();
        for (int i = 0; i < 17; i++) msg.push_back(8'(i));
        runMessage(msg, "seventeen");

        // Backpressure held for five cycles from EMIT entry.
        msg = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        buildExpected(msg);
        for (int i = 0; i < 3; i++) sendByte(msg[i], 1'b0);
        IFULL = 1'b1;
        sendByte(msg[3], 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("full_novalid%0d", i), {63'd0, OWORD_VALID}, 64'd0);
            checkOutput($sformatf("full_noready%0d", i), {63'd0, OBYTE_READY}, 64'd0);
            @(negedge ICLK);
        end
        IFULL = 1'b0;
        @(negedge ICLK);
        checkOutput("full_strobe_after_drop", {63'd0, OWORD_VALID}, 64'd1);
        waitStrobes();
        compareStrobes("full");
        releaseDigest("full");

        // Digest-ready already high at the last strobe must not release.
        IDIGEST_READY = 1'b1;
        msg = '{8'h78, 8'h79};
        buildExpected(msg);
        applyStimulus(msg);
        waitStrobes();
        compareStrobes("hold");
        IBYTE       = 8'h55;
        IBYTE_LAST  = 1'b1;
        IBYTE_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ICLK);
            checkOutput($sformatf("hold_refuse%0d", i), {63'd0, OBYTE_READY}, 64'd0);
        end
        IBYTE_VALID = 1'b0;
        IBYTE_LAST  = 1'b0;
        IDIGEST_READY = 1'b0;
        repeat (2) @(negedge ICLK);
        checkOutput("hold_low_ready", {63'd0, OBYTE_READY}, 64'd0);
        checkOutput("hold_low_busy", {63'd0, OBUSY}, 64'd1);
        IDIGEST_READY = 1'b1;
        @(negedge ICLK);
        checkOutput("hold_rise_ready", {63'd0, OBYTE_READY}, 64'd1);
        IDIGEST_READY = 1'b0;
        @(negedge ICLK);

        // Reset in the middle of a word discards it.
        for (int i = 0; i < 5; i++) sendByte(8'hC0 + 8'(i), 1'b0);
        checkOutput("midrst_busy_before", {63'd0, OBUSY}, 64'd1);
        IRST = 1'b1;
        #1;
        checkOutput("midrst_oword", OWORD, 64'd0);
        checkOutput("midrst_busy", {63'd0, OBUSY}, 64'd0);
        checkOutput("midrst_ready", {63'd0, OBYTE_READY}, 64'd0);
        checkOutput("midrst_valid", {63'd0, OWORD_VALID}, 64'd0);
        @(negedge ICLK);
        IRST = 1'b0;
        @(negedge ICLK);
        obs_q.delete();
        msg = '{8'h61, 8'h62, 8'h63};
        runMessage(msg, "abc_after_rst");

        // Random messages with random backpressure.
        rand_full = 1;
        for (int m = 0; m < 8; m++) begin
            int len = $urandom_range(1, 20);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
            runMessage(msg, $sformatf("rand%0d", m));
        end
        rand_full = 0;
        IFULL = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
